// File: rtl/imm_gen_pipe_if.sv
// Decode-stage handshake bundle: instruction in (valid/ready), decoded immediate out (valid/ready).
interface imm_gen_pipe_if #(
   parameter int XLEN = 32,
   parameter int PC_W = XLEN
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic            out_illegal;
   logic [31:0]     out_instr;
   logic [PC_W-1:0] out_pc;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_pc
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_pc
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: 1-cycle registered decode, full throughput.
// Output register + skid register; in_ready comes only from skid occupancy, never from out_ready.
module imm_gen_pipe #(
   parameter int XLEN = 32,
   parameter int PC_W = XLEN
) (
   input  logic          clk,
   input  logic          rst,
   imm_gen_pipe_if.slave bus
);
   localparam logic [2:0] FMT_I     = 3'd0;
   localparam logic [2:0] FMT_S     = 3'd1;
   localparam logic [2:0] FMT_B     = 3'd2;
   localparam logic [2:0] FMT_U     = 3'd3;
   localparam logic [2:0] FMT_J     = 3'd4;
   localparam logic [2:0] FMT_SHAMT = 3'd5;
   localparam logic [2:0] FMT_ZIMM  = 3'd6;
   localparam logic [2:0] FMT_NONE  = 3'd7;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
   } ent_t;

   localparam ent_t ENT_RST = '{fmt: FMT_NONE, default: '0};

   logic [31:0]        ins;
   logic [6:0]         op;
   logic [2:0]         f3;
   logic [5:0]         shamt;
   logic signed [31:0] simm;
   ent_t               dec;

   assign ins   = bus.in_instr;
   assign op    = ins[6:0];
   assign f3    = ins[14:12];
   assign shamt = (XLEN == 64) ? ins[25:20] : {1'b0, ins[24:20]};

   always_comb begin
      dec       = ENT_RST;
      dec.instr = ins;
      dec.pc    = bus.in_pc;
      simm      = '0;
      case (op)
         OP_IMM: begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
               dec.fmt = FMT_SHAMT;
               dec.imm = XLEN'(shamt);
            end else begin
               dec.fmt = FMT_I;
               simm    = {{20{ins[31]}}, ins[31:20]};
            end
         end
         OP_LOAD, OP_JALR: begin
            dec.fmt = FMT_I;
            simm    = {{20{ins[31]}}, ins[31:20]};
         end
         OP_STORE: begin
            dec.fmt = FMT_S;
            simm    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         end
         OP_BRANCH: begin
            dec.fmt = FMT_B;
            simm    = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            dec.fmt = FMT_U;
            simm    = {ins[31:12], 12'b0};
         end
         OP_JAL: begin
            dec.fmt = FMT_J;
            simm    = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         end
         OP_SYSTEM: begin
            if (f3[2]) begin
               dec.fmt = FMT_ZIMM;
               dec.imm = XLEN'(ins[19:15]);
            end
         end
         default: dec.illegal = 1'b1;
      endcase
      // simm is signed, so the size cast sign-extends to XLEN
      if (dec.fmt <= FMT_J) begin
         dec.imm = XLEN'(simm);
      end
   end

   ent_t out_q, out_d, skid_q, skid_d;
   logic out_valid_q, out_valid_d;
   logic skid_valid_q, skid_valid_d;
   logic in_fire, out_fire;

   assign in_fire  = bus.in_valid && !skid_valid_q;
   assign out_fire = out_valid_q && bus.out_ready;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (!out_valid_q || out_fire) begin
         // skid can only be occupied while the output register is too, so it always drains first
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= ENT_RST;
         out_valid_q  <= 1'b0;
         skid_q       <= ENT_RST;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign bus.in_ready    = !skid_valid_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_fmt     = out_q.fmt;
   assign bus.out_illegal = out_q.illegal;
   assign bus.out_instr   = out_q.instr;
   assign bus.out_pc      = out_q.pc;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised scoreboard bench for imm_gen_pipe (XLEN=32 pipeline plus an XLEN=64 decode instance).
module tb_imm_gen_pipe;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .PC_W(32)) if32 ();
   imm_gen_pipe_if #(.XLEN(64), .PC_W(64)) if64 ();

   imm_gen_pipe #(.XLEN(32), .PC_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
   imm_gen_pipe #(.XLEN(64), .PC_W(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } txn_t;

   txn_t        q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_out = 0;
   logic        p64v = 1'b0;
   logic [31:0] p64_instr;
   logic [63:0] p64_pc;

   logic [31:0] sw_ins [5];
   logic [31:0] sw_imm [5];
   logic [2:0]  sw_fmt [5];
   logic        sw_ill [5];
   logic [31:0] strm   [4];

   // Immediates from the ISA field rules, using arithmetic shifts on the sign-extended word
   function automatic exp_t model(input logic [31:0] ins, input int xlen);
      exp_t   e;
      longint sx;
      sx    = longint'($signed(ins));
      e.imm = '0;
      e.fmt = 3'd7;
      e.ill = 1'b0;
      case (ins[6:0])
         7'h13: begin
            if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
               e.fmt = 3'd5;
               e.imm = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
            end else begin
               e.fmt = 3'd0;
               e.imm = sx >>> 20;
            end
         end
         7'h03, 7'h67: begin e.fmt = 3'd0; e.imm = sx >>> 20; end
         7'h23: begin e.fmt = 3'd1; e.imm = ((sx >>> 25) <<< 5) | longint'(ins[11:7]); end
         7'h63: begin
            e.fmt = 3'd2;
            e.imm = ((sx >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                  | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
         end
         7'h37, 7'h17: begin e.fmt = 3'd3; e.imm = sx & 64'hFFFF_FFFF_FFFF_F000; end
         7'h6F: begin
            e.fmt = 3'd4;
            e.imm = ((sx >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                  | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
         end
         7'h73: if (ins[14]) begin e.fmt = 3'd6; e.imm = 64'(ins[19:15]); end
         default: e.ill = 1'b1;
      endcase
      if (xlen == 32) e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 9) != 0) begin
         case ($urandom_range(0, 8))
            0: r[6:0] = 7'h13;
            1: r[6:0] = 7'h03;
            2: r[6:0] = 7'h67;
            3: r[6:0] = 7'h23;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h37;
            6: r[6:0] = 7'h17;
            7: r[6:0] = 7'h6F;
            default: r[6:0] = 7'h73;
         endcase
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      check("out_valid", 64'(if32.out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(if32.in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
         e = model(q[0].instr, 32);
         check("out_imm", 64'(if32.out_imm), e.imm);
         check("out_fmt", 64'(if32.out_fmt), 64'(e.fmt));
         check("out_illegal", 64'(if32.out_illegal), 64'(e.ill));
         check("out_instr", 64'(if32.out_instr), 64'(q[0].instr));
         check("out_pc", 64'(if32.out_pc), 64'(q[0].pc));
      end
      if (p64v) begin
         e = model(p64_instr, 64);
         check("out_valid64", 64'(if64.out_valid), 64'd1);
         check("out_imm64", if64.out_imm, e.imm);
         check("out_fmt64", 64'(if64.out_fmt), 64'(e.fmt));
         check("out_illegal64", 64'(if64.out_illegal), 64'(e.ill));
         check("out_pc64", if64.out_pc, p64_pc);
      end
   endtask

   // One clock cycle: check outputs at the falling edge, drive inputs, advance the model
   task automatic tick(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic [31:0] ins64);
      logic acc, pop;
      check_outputs();
      if32.in_valid  = v;
      if32.in_instr  = ins;
      if32.in_pc     = pc;
      if32.out_ready = ordy;
      if64.in_valid  = 1'b1;
      if64.in_instr  = ins64;
      if64.in_pc     = {$urandom, $urandom};
      if64.out_ready = 1'b1;
      acc = v && (q.size() < 2);
      pop = (q.size() > 0) && ordy;
      if (pop) begin
         void'(q.pop_front());
         n_out++;
      end
      if (acc) q.push_back('{instr: ins, pc: pc});
      p64v      = 1'b1;
      p64_instr = ins64;
      p64_pc    = if64.in_pc;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      if32.in_valid  = 1'b1;
      if32.in_instr  = 32'h0010_0093;
      if32.in_pc     = 32'hDEAD_0000;
      if32.out_ready = 1'b1;
      if64.in_valid  = 1'b1;
      if64.out_ready = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      q.delete();
      p64v = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, 64'(if32.out_valid), 64'd0);
      check({tag, "_in_ready"}, 64'(if32.in_ready), 64'd1);
      check({tag, "_fmt"}, 64'(if32.out_fmt), 64'd7);
      check({tag, "_imm"}, 64'(if32.out_imm), 64'd0);
      check({tag, "_illegal"}, 64'(if32.out_illegal), 64'd0);
      check({tag, "_instr"}, 64'(if32.out_instr), 64'd0);
      check({tag, "_pc"}, 64'(if32.out_pc), 64'd0);
   endtask

   initial begin
      int idx;
      int n_out0;
      logic v, ordy, acc_will;

      sw_ins = '{32'hFE20_AE23, 32'h1234_52B7, 32'h4030_D093, 32'h3002_D073, 32'h0000_007F};
      sw_imm = '{32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000};
      sw_fmt = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd7};
      sw_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      strm   = '{32'h0050_0113, 32'h0020_A423, 32'hFE00_0EE3, 32'h8000_00EF};

      rst            = 1'b1;
      if32.in_valid  = 1'b0;
      if32.in_instr  = '0;
      if32.in_pc     = '0;
      if32.out_ready = 1'b0;
      if64.in_valid  = 1'b0;
      if64.in_instr  = '0;
      if64.in_pc     = '0;
      if64.out_ready = 1'b0;
      @(negedge clk);
      do_reset();
      check_reset_state("reset");
      check("reset_fmt64", 64'(if64.out_fmt), 64'd7);

      // ADDI x1, x0, -1 plus LUI 0x80000 on the 64-bit instance
      tick(1'b1, 32'hFFF0_0093, 32'h0000_1000, 1'b1, 32'h8000_02B7);
      check("addi_valid", 64'(if32.out_valid), 64'd1);
      check("addi_imm", 64'(if32.out_imm), 64'hFFFF_FFFF);
      check("addi_fmt", 64'(if32.out_fmt), 64'd0);
      check("addi_illegal", 64'(if32.out_illegal), 64'd0);
      check("addi_pc", 64'(if32.out_pc), 64'h1000);
      check("lui64_imm", if64.out_imm, 64'hFFFF_FFFF_8000_0000);
      check("lui64_fmt", 64'(if64.out_fmt), 64'd3);

      for (int i = 0; i < 5; i++) begin
         tick(1'b1, sw_ins[i], 32'h2000 + 32'(i * 4), 1'b1, rand_instr());
         check($sformatf("sweep%0d_imm", i), 64'(if32.out_imm), 64'(sw_imm[i]));
         check($sformatf("sweep%0d_fmt", i), 64'(if32.out_fmt), 64'(sw_fmt[i]));
         check($sformatf("sweep%0d_illegal", i), 64'(if32.out_illegal), 64'(sw_ill[i]));
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, rand_instr());

      // Four-deep stream with the consumer stalled for cycles 2..4
      idx    = 0;
      n_out0 = n_out;
      for (int c = 1; c <= 40 && (idx < 4 || q.size() > 0); c++) begin
         ordy     = !(c >= 2 && c <= 4);
         v        = (idx < 4);
         acc_will = v && (q.size() < 2);
         if (c == 3) check("bp_in_ready_low", 64'(if32.in_ready), 64'd0);
         if (c >= 3 && c <= 5) check($sformatf("bp_hold_A_c%0d", c), 64'(if32.out_instr), 64'(strm[0]));
         tick(v, strm[(idx < 4) ? idx : 0], 32'h3000 + 32'(idx * 4), ordy, rand_instr());
         if (acc_will) idx++;
      end
      check("bp_emitted", 64'(n_out - n_out0), 64'd4);
      check("bp_drained", 64'(q.size()), 64'd0);

      // Reset with both entries occupied
      tick(1'b1, 32'h0010_0093, 32'h4000, 1'b1, rand_instr());
      tick(1'b1, 32'h0020_0113, 32'h4004, 1'b0, rand_instr());
      check("full_in_ready", 64'(if32.in_ready), 64'd0);
      do_reset();
      check_reset_state("midrst");
      tick(1'b1, 32'hFFF0_0093, 32'h5000, 1'b1, rand_instr());
      check("postrst_valid", 64'(if32.out_valid), 64'd1);
      check("postrst_instr", 64'(if32.out_instr), 64'hFFF0_0093);

      for (int c = 0; c < 10000; c++) begin
         tick($urandom_range(0, 3) != 0, rand_instr(), $urandom,
              $urandom_range(0, 3) != 0, rand_instr());
      end
      for (int c = 0; c < 4; c++) tick(1'b0, 32'h0, 32'h0, 1'b1, rand_instr());
      check_outputs();
      check("final_drained", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
